// File: rtl/branch_target_buffer_if.sv
// Lookup/update bus between the IF/EX pipeline stages and the branch target buffer.
// The pipeline side is the master; the predictor is the slave.
interface branch_target_buffer_if #(
    parameter int ADDR_W = 32
);
    logic [ADDR_W-1:0] lk_pc;
    logic              lk_hit;
    logic              lk_taken;
    logic [ADDR_W-1:0] lk_target;
    logic              upd_valid;
    logic [ADDR_W-1:0] upd_pc;
    logic              upd_taken;
    logic [ADDR_W-1:0] upd_target;
    logic              inv_all;

    modport master (
        output lk_pc,
        input  lk_hit,
        input  lk_taken,
        input  lk_target,
        output upd_valid,
        output upd_pc,
        output upd_taken,
        output upd_target,
        output inv_all
    );

    modport slave (
        input  lk_pc,
        output lk_hit,
        output lk_taken,
        output lk_target,
        input  upd_valid,
        input  upd_pc,
        input  upd_taken,
        input  upd_target,
        input  inv_all
    );
endinterface

// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer with saturating direction counters.
// Lookups are combinational for the IF stage; resolved outcomes from EX update the table.
module branch_target_buffer #(
    parameter int ENTRIES = 16,
    parameter int TAG_W   = 8,
    parameter int CTR_W   = 2,
    parameter int ADDR_W  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    branch_target_buffer_if.slave bus
);
    localparam int              IDX_W    = $clog2(ENTRIES);
    localparam logic [CTR_W-1:0] CTR_MAX  = {CTR_W{1'b1}};
    localparam logic [CTR_W-1:0] CTR_ZERO = {CTR_W{1'b0}};
    localparam logic [CTR_W-1:0] CTR_ONE  = CTR_W'(1);
    localparam logic [CTR_W-1:0] CTR_WEAK = CTR_W'(1) << (CTR_W - 1);

    logic              valid_q  [ENTRIES];
    logic [TAG_W-1:0]  tag_q    [ENTRIES];
    logic [ADDR_W-1:0] target_q [ENTRIES];
    logic [CTR_W-1:0]  ctr_q    [ENTRIES];

    logic [IDX_W-1:0]  lk_idx_s;
    logic [TAG_W-1:0]  lk_tag_s;
    logic              lk_hit_s;
    logic              lk_taken_s;
    logic [ADDR_W-1:0] lk_target_s;

    logic [IDX_W-1:0]  upd_idx_s;
    logic [TAG_W-1:0]  upd_tag_s;
    logic              upd_hit_s;
    logic              wr_en_s;
    logic              valid_d;
    logic [TAG_W-1:0]  tag_d;
    logic [ADDR_W-1:0] target_d;
    logic [CTR_W-1:0]  ctr_d;

    // Lookup: table read of the current PC; a not-taken prediction falls through to pc+4.
    always_comb begin
        lk_idx_s    = bus.lk_pc[IDX_W+1:2];
        lk_tag_s    = bus.lk_pc[IDX_W+TAG_W+1:IDX_W+2];
        lk_hit_s    = valid_q[lk_idx_s] && (tag_q[lk_idx_s] == lk_tag_s);
        lk_taken_s  = lk_hit_s && ctr_q[lk_idx_s][CTR_W-1];
        if (lk_taken_s) begin
            lk_target_s = target_q[lk_idx_s];
        end else begin
            lk_target_s = bus.lk_pc + ADDR_W'(4);
        end
    end

    assign bus.lk_hit    = lk_hit_s;
    assign bus.lk_taken  = lk_taken_s;
    assign bus.lk_target = lk_target_s;

    // Update: train the counter on a hit, allocate only on a taken miss.
    always_comb begin
        upd_idx_s = bus.upd_pc[IDX_W+1:2];
        upd_tag_s = bus.upd_pc[IDX_W+TAG_W+1:IDX_W+2];
        upd_hit_s = valid_q[upd_idx_s] && (tag_q[upd_idx_s] == upd_tag_s);
        wr_en_s   = 1'b0;
        valid_d   = valid_q[upd_idx_s];
        tag_d     = tag_q[upd_idx_s];
        target_d  = target_q[upd_idx_s];
        ctr_d     = ctr_q[upd_idx_s];
        if (bus.upd_valid) begin
            if (upd_hit_s) begin
                wr_en_s = 1'b1;
                if (bus.upd_taken) begin
                    target_d = bus.upd_target;
                    if (ctr_q[upd_idx_s] == CTR_MAX) begin
                        ctr_d = CTR_MAX;
                    end else begin
                        ctr_d = ctr_q[upd_idx_s] + CTR_ONE;
                    end
                end else begin
                    if (ctr_q[upd_idx_s] == CTR_ZERO) begin
                        ctr_d = CTR_ZERO;
                    end else begin
                        ctr_d = ctr_q[upd_idx_s] - CTR_ONE;
                    end
                end
            end else if (bus.upd_taken) begin
                wr_en_s  = 1'b1;
                valid_d  = 1'b1;
                tag_d    = upd_tag_s;
                target_d = bus.upd_target;
                ctr_d    = CTR_WEAK;
            end else begin
                wr_en_s = 1'b0;
            end
        end else begin
            wr_en_s = 1'b0;
        end
    end

    // Table storage; reset and invalidate-all both empty the table and win over updates.
    always_ff @(posedge clk) begin
        if (rst || bus.inv_all) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= {TAG_W{1'b0}};
                target_q[i] <= {ADDR_W{1'b0}};
                ctr_q[i]    <= CTR_ZERO;
            end
        end else if (wr_en_s) begin
            valid_q[upd_idx_s]  <= valid_d;
            tag_q[upd_idx_s]    <= tag_d;
            target_q[upd_idx_s] <= target_d;
            ctr_q[upd_idx_s]    <= ctr_d;
        end
    end
endmodule

// File: tb/tb_branch_target_buffer.sv
// Directed-vector bench for branch_target_buffer (ENTRIES=16, TAG_W=8, CTR_W=2).
module tb_branch_target_buffer;
    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    branch_target_buffer_if #(.ADDR_W(32)) bus ();

    branch_target_buffer #(
        .ENTRIES(16), .TAG_W(8), .CTR_W(2), .ADDR_W(32)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic look(input string tag, input logic [31:0] pc, input logic hit,
                        input logic taken, input logic [31:0] target);
        bus.lk_pc = pc;
        #1;
        chk({tag, ".hit"},    {31'd0, bus.lk_hit},   {31'd0, hit});
        chk({tag, ".taken"},  {31'd0, bus.lk_taken}, {31'd0, taken});
        chk({tag, ".target"}, bus.lk_target,         target);
    endtask

    task automatic upd(input logic [31:0] pc, input logic taken, input logic [31:0] target);
        bus.upd_valid  = 1'b1;
        bus.upd_pc     = pc;
        bus.upd_taken  = taken;
        bus.upd_target = target;
        tick();
        bus.upd_valid  = 1'b0;
    endtask

    localparam logic [31:0] PA = 32'h0040_0010;
    localparam logic [31:0] PB = 32'h0040_0410;
    localparam logic [31:0] PC = 32'h0040_0020;
    localparam logic [31:0] PD = 32'h0040_0030;

    initial begin
        n_vec = 0;
        n_err = 0;
        rst = 1'b1;
        bus.lk_pc = 32'h0;
        bus.upd_valid = 1'b0;
        bus.upd_pc = 32'h0;
        bus.upd_taken = 1'b0;
        bus.upd_target = 32'h0;
        bus.inv_all = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        look("reset", PA, 1'b0, 1'b0, 32'h0040_0014);

        upd(PA, 1'b1, 32'h0040_0040);
        look("alloc", PA, 1'b1, 1'b1, 32'h0040_0040);

        // counter walks down and sticks at zero
        upd(PA, 1'b0, 32'h0);
        look("nt1", PA, 1'b1, 1'b0, 32'h0040_0014);
        upd(PA, 1'b0, 32'h0);
        look("nt2", PA, 1'b1, 1'b0, 32'h0040_0014);
        upd(PA, 1'b0, 32'h0);
        upd(PA, 1'b1, 32'h0040_0040);
        look("sat0", PA, 1'b1, 1'b0, 32'h0040_0014);
        upd(PA, 1'b1, 32'h0040_0040);
        look("back2", PA, 1'b1, 1'b1, 32'h0040_0040);

        // counter walks up and sticks at three; taken update retargets
        upd(PA, 1'b1, 32'h0040_0040);
        upd(PA, 1'b1, 32'h0040_0040);
        upd(PA, 1'b1, 32'h0040_0080);
        upd(PA, 1'b0, 32'h0000_1234);
        look("sat3", PA, 1'b1, 1'b1, 32'h0040_0080);
        upd(PA, 1'b0, 32'h0);
        look("ctr1", PA, 1'b1, 1'b0, 32'h0040_0014);
        upd(PA, 1'b1, 32'h0040_0040);

        // aliasing entry: no allocation on not-taken miss, replacement on taken miss
        look("aliasmiss", PB, 1'b0, 1'b0, 32'h0040_0414);
        upd(PB, 1'b0, 32'h0040_0900);
        look("noalloc", PB, 1'b0, 1'b0, 32'h0040_0414);
        look("keepA", PA, 1'b1, 1'b1, 32'h0040_0040);
        upd(PB, 1'b1, 32'h0040_0800);
        look("replB", PB, 1'b1, 1'b1, 32'h0040_0800);
        look("evictA", PA, 1'b0, 1'b0, 32'h0040_0014);

        // lookup concurrent with update sees pre-update contents
        bus.lk_pc = PB;
        bus.upd_valid = 1'b1;
        bus.upd_pc = PB;
        bus.upd_taken = 1'b0;
        bus.upd_target = 32'h0;
        #1;
        chk("bypass.taken", {31'd0, bus.lk_taken}, 32'd1);
        tick();
        bus.upd_valid = 1'b0;
        look("postupd", PB, 1'b1, 1'b0, 32'h0040_0414);

        upd(PC, 1'b1, 32'h0040_0100);
        look("otheridx", PC, 1'b1, 1'b1, 32'h0040_0100);

        // invalidate-all beats a same-cycle update
        bus.inv_all = 1'b1;
        bus.upd_valid = 1'b1;
        bus.upd_pc = PD;
        bus.upd_taken = 1'b1;
        bus.upd_target = 32'h0040_0200;
        tick();
        bus.inv_all = 1'b0;
        bus.upd_valid = 1'b0;
        look("invB", PB, 1'b0, 1'b0, 32'h0040_0414);
        look("invC", PC, 1'b0, 1'b0, 32'h0040_0024);
        look("invD", PD, 1'b0, 1'b0, 32'h0040_0034);

        look("wrap", 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0000_0000);

        // reset beats a same-cycle update
        upd(PC, 1'b1, 32'h0040_0100);
        rst = 1'b1;
        bus.upd_valid = 1'b1;
        bus.upd_pc = PD;
        bus.upd_taken = 1'b1;
        bus.upd_target = 32'h0040_0200;
        tick();
        rst = 1'b0;
        bus.upd_valid = 1'b0;
        look("rstC", PC, 1'b0, 1'b0, 32'h0040_0024);
        look("rstD", PD, 1'b0, 1'b0, 32'h0040_0034);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
